// File: rtl/i2c_pkg.sv
// Shared definitions for the oversampled I2C target: FSM states, ACK levels and the TMP10X address.
package i2c_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } i2c_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam logic [6:0] TMP10X_ADDRESS = 7'h48;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser followed by a glitch filter that only follows the input after
// FILTER_LEN identical samples; emits one-cycle rise/fall strobes on the filtered level.
module i2c_line_filter #(
   parameter int unsigned FILTER_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [3:0] LAST = 4'(FILTER_LEN - 1);

   logic [1:0] sync;
   logic [3:0] count;

   // Idle bus is high, so everything resets to 1 to avoid a spurious edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= '1;
         level <= 1'b1;
         count <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync[1] == level) begin
            count <= '0;
         end else if (count == LAST) begin
            level <= sync[1];
            count <= '0;
            rise  <= sync[1];
            fall  <= ~sync[1];
         end else begin
            count <= count + 4'd1;
         end
      end
   end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C target that oversamples Scl/Sda on Clk, matches DEVICE_ADDRESS and exposes
// a byte-stream write/read handshake with per-byte ACK decision.
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter int unsigned               ADDRESSLENGTH  = 7,
   parameter logic [ADDRESSLENGTH-1:0]  DEVICE_ADDRESS = ADDRESSLENGTH'(TMP10X_ADDRESS),
   parameter int unsigned               FILTER_LEN     = 3
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       SclIn,
   input  logic       SdaIn,
   output logic       SdaOe,
   output logic [7:0] RxData,
   output logic       RxValid,
   output logic       RxFirst,
   input  logic       RxReady,
   output logic       TxReq,
   input  logic [7:0] TxData,
   output logic       RorW,
   output logic       Busy,
   output logic       Selected
);

   localparam logic [3:0] ADDR_BITS = 4'(ADDRESSLENGTH);

   logic scl, scl_rise, scl_fall;
   logic sda, sda_rise, sda_fall;

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk(Clk), .reset(Reset), .raw(SclIn), .level(scl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk(Clk), .reset(Reset), .raw(SdaIn), .level(sda), .rise(sda_rise), .fall(sda_fall)
   );

   logic start_det, stop_det;
   assign start_det = sda_fall & scl;
   assign stop_det  = sda_rise & scl;

   i2c_state_t               state, state_n;
   logic [3:0]               cnt, cnt_n;
   logic [7:0]               shift, shift_n;
   logic [ADDRESSLENGTH-1:0] addr, addr_n;
   logic                     first, first_n;
   logic                     sda_oe_n, rx_valid_n, rx_first_n, tx_req_n;
   logic                     rorw_n, busy_n, selected_n;
   logic [7:0]               rx_data_n;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         shift    <= '0;
         addr     <= '0;
         first    <= 1'b0;
         SdaOe    <= 1'b0;
         RxData   <= '0;
         RxValid  <= 1'b0;
         RxFirst  <= 1'b0;
         TxReq    <= 1'b0;
         RorW     <= 1'b0;
         Busy     <= 1'b0;
         Selected <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         shift    <= shift_n;
         addr     <= addr_n;
         first    <= first_n;
         SdaOe    <= sda_oe_n;
         RxData   <= rx_data_n;
         RxValid  <= rx_valid_n;
         RxFirst  <= rx_first_n;
         TxReq    <= tx_req_n;
         RorW     <= rorw_n;
         Busy     <= busy_n;
         Selected <= selected_n;
      end
   end

   always_comb begin
      state_n = state;
      if (start_det) begin
         state_n = ADDR;
      end else if (stop_det) begin
         state_n = IDLE;
      end else begin
         unique case (state)
            ADDR:     if (scl_fall && cnt == ADDR_BITS + 4'd1)
                         state_n = (addr == DEVICE_ADDRESS) ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (scl_fall) state_n = RorW ? RD_DATA : WR_DATA;
            WR_DATA:  if (scl_fall && cnt == 4'd8) state_n = RxReady ? WR_ACK : IGNORE;
            WR_ACK:   if (scl_fall) state_n = WR_DATA;
            RD_DATA:  if (scl_fall && cnt == 4'd8) state_n = RD_ACK;
            RD_ACK: begin
               if (scl_rise && sda != I2C_ACK) state_n = IGNORE;
               else if (scl_fall)             state_n = RD_DATA;
            end
            default: ;
         endcase
      end
   end

   // Read bytes: bit7 is driven at the fall that loads TxData, so cnt starts at 1.
   always_comb begin
      cnt_n      = cnt;
      shift_n    = shift;
      addr_n     = addr;
      first_n    = first;
      sda_oe_n   = SdaOe;
      rx_data_n  = RxData;
      rx_valid_n = 1'b0;
      rx_first_n = RxFirst;
      tx_req_n   = 1'b0;
      rorw_n     = RorW;
      busy_n     = Busy;
      selected_n = Selected;
      if (start_det) begin
         cnt_n      = '0;
         first_n    = 1'b0;
         busy_n     = 1'b1;
         selected_n = 1'b0;
         sda_oe_n   = 1'b0;
      end else if (stop_det) begin
         busy_n     = 1'b0;
         selected_n = 1'b0;
         sda_oe_n   = 1'b0;
      end else begin
         unique case (state)
            ADDR: begin
               if (scl_rise) begin
                  if (cnt < ADDR_BITS) addr_n = {addr[ADDRESSLENGTH-2:0], sda};
                  else                 rorw_n = sda;
                  cnt_n = cnt + 4'd1;
               end else if (scl_fall && cnt == ADDR_BITS + 4'd1) begin
                  cnt_n = '0;
                  if (addr == DEVICE_ADDRESS) begin
                     sda_oe_n   = 1'b1;
                     selected_n = 1'b1;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_rise && RorW) begin
                  tx_req_n = 1'b1;
               end else if (scl_fall) begin
                  if (RorW) begin
                     sda_oe_n = ~TxData[7];
                     shift_n  = {TxData[6:0], 1'b0};
                     cnt_n    = 4'd1;
                  end else begin
                     sda_oe_n = 1'b0;
                     cnt_n    = '0;
                     first_n  = 1'b1;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shift_n = {shift[6:0], sda};
                  cnt_n   = cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     rx_valid_n = 1'b1;
                     rx_data_n  = {shift[6:0], sda};
                     rx_first_n = first;
                     first_n    = 1'b0;
                  end
               end else if (scl_fall && cnt == 4'd8) begin
                  sda_oe_n = RxReady;
                  cnt_n    = '0;
               end
            end
            WR_ACK: if (scl_fall) sda_oe_n = 1'b0;
            RD_DATA: begin
               if (scl_fall) begin
                  if (cnt == 4'd8) begin
                     sda_oe_n = 1'b0;
                     cnt_n    = '0;
                  end else begin
                     sda_oe_n = ~shift[7];
                     shift_n  = {shift[6:0], 1'b0};
                     cnt_n    = cnt + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && sda == I2C_ACK) begin
                  tx_req_n = 1'b1;
               end else if (scl_fall) begin
                  sda_oe_n = ~TxData[7];
                  shift_n  = {TxData[6:0], 1'b0};
                  cnt_n    = 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: a bit-banged master drives the bus, the pad is
// modelled as wired-AND with the target's SdaOe pull-down.
module tb_i2c_slave_ctrl;

   localparam int Q = 12;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       scl_glitch = 1'b0;
   logic       SclIn, SdaIn, SdaOe;
   logic [7:0] RxData;
   logic       RxValid, RxFirst;
   logic       RxReady = 1'b1;
   logic       TxReq;
   logic [7:0] TxData;
   logic       RorW, Busy, Selected;

   int checks = 0;
   int failures = 0;

   int         rx_cnt = 0;
   logic [7:0] rx_data_log [16];
   logic       rx_first_log [16];
   int         tx_req_cnt = 0;
   logic [7:0] tx_vals [4];

   assign SclIn = m_scl ^ scl_glitch;
   assign SdaIn = m_sda & ~SdaOe;

   always #5 Clk = ~Clk;

   i2c_slave_ctrl #(
      .ADDRESSLENGTH(7),
      .DEVICE_ADDRESS(7'h48),
      .FILTER_LEN(3)
   ) dut (
      .Clk(Clk), .Reset(Reset), .SclIn(SclIn), .SdaIn(SdaIn), .SdaOe(SdaOe),
      .RxData(RxData), .RxValid(RxValid), .RxFirst(RxFirst), .RxReady(RxReady),
      .TxReq(TxReq), .TxData(TxData), .RorW(RorW), .Busy(Busy), .Selected(Selected)
   );

   // Sink/source model: log received bytes, answer TxReq with the next queued read byte.
   initial begin
      TxData = 8'h00;
      forever begin
         @(negedge Clk);
         if (RxValid === 1'b1) begin
            rx_data_log[rx_cnt % 16]  = RxData;
            rx_first_log[rx_cnt % 16] = RxFirst;
            rx_cnt++;
         end
         if (TxReq === 1'b1) begin
            TxData = tx_vals[tx_req_cnt % 4];
            tx_req_cnt++;
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic glitch_pulse();
      scl_glitch = 1'b1;
      wait_clks(1);
      scl_glitch = 1'b0;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wait_clks(Q);
      m_scl = 1'b1; wait_clks(Q);
      m_sda = 1'b0; wait_clks(Q);
      m_scl = 1'b0; wait_clks(Q);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wait_clks(Q);
      m_scl = 1'b1; wait_clks(Q);
      m_sda = 1'b1; wait_clks(Q);
   endtask

   // g: 0 none, 1 one-Clk Scl glitch while low, 2 one-Clk Scl glitch while high
   task automatic write_bit(input logic b, input int g);
      m_sda = b;
      wait_clks(Q / 2);
      if (g == 1) glitch_pulse();
      wait_clks(Q / 2);
      m_scl = 1'b1;
      wait_clks(Q / 2);
      if (g == 2) glitch_pulse();
      wait_clks(Q / 2);
      m_scl = 1'b0;
      wait_clks(Q);
   endtask

   task automatic read_bit(output logic b);
      m_sda = 1'b1; wait_clks(Q);
      m_scl = 1'b1; wait_clks(Q);
      b = SdaIn;    wait_clks(Q);
      m_scl = 1'b0; wait_clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic nack,
                             input int lo_bit = -1, input int hi_bit = -1);
      for (int i = 7; i >= 0; i--)
         write_bit(d[i], (i == lo_bit) ? 1 : ((i == hi_bit) ? 2 : 0));
      read_bit(nack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic master_nack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(master_nack, 0);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      wait_clks(4);
      checks++; if (SdaOe !== 1'b0)    begin failures++; $display("FAIL reset_sdaoe got %b exp 0", SdaOe); end
      checks++; if (RxData !== 8'h00)  begin failures++; $display("FAIL reset_rxdata got %h exp 00", RxData); end
      checks++; if (RxValid !== 1'b0)  begin failures++; $display("FAIL reset_rxvalid got %b exp 0", RxValid); end
      checks++; if (TxReq !== 1'b0)    begin failures++; $display("FAIL reset_txreq got %b exp 0", TxReq); end
      checks++; if (Busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got %b exp 0", Busy); end
      checks++; if (Selected !== 1'b0) begin failures++; $display("FAIL reset_selected got %b exp 0", Selected); end
      Reset = 1'b0;
      wait_clks(Q);
   endtask

   task automatic test_write();
      logic a0, a1, a2;
      int base;
      base = rx_cnt;
      i2c_start();
      checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL wr_busy_start got %b exp 1", Busy); end
      write_byte(8'h90, a0);
      write_byte(8'h01, a1);
      write_byte(8'hA5, a2);
      checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL wr_acks got %b exp 000", {a0, a1, a2}); end
      checks++; if (Selected !== 1'b1) begin failures++; $display("FAIL wr_selected got %b exp 1", Selected); end
      checks++; if (RorW !== 1'b0) begin failures++; $display("FAIL wr_rorw got %b exp 0", RorW); end
      i2c_stop();
      wait_clks(Q);
      checks++; if (rx_cnt - base !== 2) begin failures++; $display("FAIL wr_rx_count got %0d exp 2", rx_cnt - base); end
      checks++; if ({rx_data_log[base % 16], rx_first_log[base % 16]} !== {8'h01, 1'b1})
         begin failures++; $display("FAIL wr_byte0 got %h/%b exp 01/1", rx_data_log[base % 16], rx_first_log[base % 16]); end
      checks++; if ({rx_data_log[(base + 1) % 16], rx_first_log[(base + 1) % 16]} !== {8'hA5, 1'b0})
         begin failures++; $display("FAIL wr_byte1 got %h/%b exp A5/0", rx_data_log[(base + 1) % 16], rx_first_log[(base + 1) % 16]); end
      checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL wr_busy_stop got %b exp 0", Busy); end
   endtask

   task automatic test_wrong_address();
      logic a0, a1;
      int base;
      base = rx_cnt;
      i2c_start();
      write_byte(8'h92, a0);
      checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL badaddr_nack got %b exp 1", a0); end
      checks++; if (Selected !== 1'b0) begin failures++; $display("FAIL badaddr_selected got %b exp 0", Selected); end
      checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL badaddr_busy got %b exp 1", Busy); end
      write_byte(8'h11, a1);
      checks++; if (a1 !== 1'b1) begin failures++; $display("FAIL badaddr_data_nack got %b exp 1", a1); end
      i2c_stop();
      wait_clks(Q);
      checks++; if (rx_cnt - base !== 0) begin failures++; $display("FAIL badaddr_rx_count got %0d exp 0", rx_cnt - base); end
   endtask

   task automatic test_read();
      logic a0, a1, a2;
      logic [7:0] d0, d1;
      int base, tbase;
      base  = rx_cnt;
      tbase = tx_req_cnt;
      tx_vals[tbase % 4]       = 8'h3C;
      tx_vals[(tbase + 1) % 4] = 8'hF0;
      i2c_start();
      write_byte(8'h90, a0);
      write_byte(8'h00, a1);
      i2c_start();
      write_byte(8'h91, a2);
      checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rd_acks got %b exp 000", {a0, a1, a2}); end
      checks++; if (RorW !== 1'b1) begin failures++; $display("FAIL rd_rorw got %b exp 1", RorW); end
      read_byte(d0, 1'b0);
      read_byte(d1, 1'b1);
      checks++; if (d0 !== 8'h3C) begin failures++; $display("FAIL rd_byte0 got %h exp 3C", d0); end
      checks++; if (d1 !== 8'hF0) begin failures++; $display("FAIL rd_byte1 got %h exp F0", d1); end
      checks++; if (tx_req_cnt - tbase !== 2) begin failures++; $display("FAIL rd_txreq_count got %0d exp 2", tx_req_cnt - tbase); end
      checks++; if ({Busy, Selected, SdaOe} !== 3'b110) begin failures++; $display("FAIL rd_ignore_state got %b exp 110", {Busy, Selected, SdaOe}); end
      checks++; if (rx_cnt - base !== 1 || rx_data_log[base % 16] !== 8'h00 || rx_first_log[base % 16] !== 1'b1)
         begin failures++; $display("FAIL rd_pointer_byte got cnt %0d data %h exp cnt 1 data 00", rx_cnt - base, rx_data_log[base % 16]); end
      i2c_stop();
      wait_clks(Q);
      checks++; if ({Busy, Selected} !== 2'b00) begin failures++; $display("FAIL rd_stop got %b exp 00", {Busy, Selected}); end
   endtask

   task automatic test_not_ready();
      logic a0, a1, a2;
      int base;
      base = rx_cnt;
      i2c_start();
      write_byte(8'h90, a0);
      RxReady = 1'b0;
      write_byte(8'h07, a1);
      RxReady = 1'b1;
      write_byte(8'h22, a2);
      checks++; if ({a0, a1, a2} !== 3'b011) begin failures++; $display("FAIL nr_acks got %b exp 011", {a0, a1, a2}); end
      checks++; if (rx_cnt - base !== 1 || rx_data_log[base % 16] !== 8'h07)
         begin failures++; $display("FAIL nr_rx got cnt %0d data %h exp cnt 1 data 07", rx_cnt - base, rx_data_log[base % 16]); end
      i2c_stop();
      wait_clks(Q);
   endtask

   task automatic test_glitch();
      logic a0, a1;
      int base;
      base = rx_cnt;
      i2c_start();
      write_byte(8'h90, a0);
      write_byte(8'h55, a1, 3, 5);
      checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL gl_acks got %b exp 00", {a0, a1}); end
      checks++; if (rx_cnt - base !== 1 || rx_data_log[base % 16] !== 8'h55)
         begin failures++; $display("FAIL gl_byte got cnt %0d data %h exp cnt 1 data 55", rx_cnt - base, rx_data_log[base % 16]); end
      i2c_stop();
      wait_clks(Q);
   endtask

   task automatic test_reset_mid_read();
      logic a0, a1, b;
      int base;
      tx_vals[tx_req_cnt % 4] = 8'h00;
      i2c_start();
      write_byte(8'h91, a0);
      for (int i = 0; i < 4; i++) read_bit(b);
      checks++; if (SdaOe !== 1'b1) begin failures++; $display("FAIL mr_driving got %b exp 1", SdaOe); end
      Reset = 1'b1;
      wait_clks(1);
      checks++; if ({SdaOe, RxValid, RxFirst, TxReq, RorW, Busy, Selected} !== 7'b0)
         begin failures++; $display("FAIL mr_outputs got %b exp 0000000", {SdaOe, RxValid, RxFirst, TxReq, RorW, Busy, Selected}); end
      checks++; if (RxData !== 8'h00) begin failures++; $display("FAIL mr_rxdata got %h exp 00", RxData); end
      Reset = 1'b0;
      m_sda = 1'b1;
      m_scl = 1'b1;
      wait_clks(Q);
      base = rx_cnt;
      i2c_start();
      write_byte(8'h90, a0);
      write_byte(8'h5A, a1);
      i2c_stop();
      wait_clks(Q);
      checks++; if ({a0, a1} !== 2'b00) begin failures++; $display("FAIL mr_after_acks got %b exp 00", {a0, a1}); end
      checks++; if (rx_cnt - base !== 1 || rx_data_log[base % 16] !== 8'h5A || rx_first_log[base % 16] !== 1'b1)
         begin failures++; $display("FAIL mr_after_byte got cnt %0d data %h exp cnt 1 data 5A", rx_cnt - base, rx_data_log[base % 16]); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) tx_vals[i] = 8'h00;
      test_reset();
      test_write();
      test_wrong_address();
      test_read();
      test_not_ready();
      test_glitch();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
